// File: rtl/dso_pkg.sv
// Shared types and default timing constants for the host command receive path.
package dso_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int CMD_W            = 24;
  localparam int BYTES_PER_CMD    = 3;
  localparam int BAUD_DIV_DFLT    = 347;      // 40 MHz / 115200
  localparam int TIMEOUT_CYC_DFLT = 1000000;  // 25 ms at 40 MHz

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: two-flop synchronizer, baud counter and start/data/stop FSM.
module uart_rx_byte
  import dso_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frm_err_o,
  output logic       busy_o
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          rx_meta_q, rx_s_q;
  logic          byte_vld_q, byte_vld_d;
  logic          frm_err_q, frm_err_d;
  logic          shift_en;
  logic [7:0]    shift_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Data bits arrive LSB first, so shift in at the MSB.
  always_ff @(posedge clk_i) begin
    if (shift_en) shift_q <= {rx_s_q, shift_q[7:1]};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == BIT_LAST) ? '0 : cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Mid-start-bit check; a high line here was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          byte_vld_d = rx_s_q;
          frm_err_d  = !rx_s_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o     = shift_q;
  assign byte_vld_o = byte_vld_q;
  assign frm_err_o  = frm_err_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: rtl/cmd_rx_assembler.sv
// Assembles three UART bytes into a 24-bit command with cmd_rdy handshake,
// inter-byte timeout and overrun detection.
module cmd_rx_assembler
  import dso_pkg::*;
#(
  parameter int BAUD_DIV    = BAUD_DIV_DFLT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX,
  input  logic             clr_cmd_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  output logic             frm_err,
  output logic             overrun,
  output logic             rx_busy
);

  localparam int            TW        = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_CMD - 1);

  logic [7:0]       rx_byte;
  logic             byte_vld;
  logic             complete;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      shadow_q;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_i       (RX),
    .byte_o     (rx_byte),
    .byte_vld_o (byte_vld),
    .frm_err_o  (frm_err),
    .busy_o     (rx_busy)
  );

  assign complete = byte_vld && (byte_cnt_q == LAST_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      timer_q    <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      overrun_q  <= overrun_d;
    end
  end

  // The last byte goes straight into cmd, so only the first two are held.
  always_ff @(posedge clk) begin
    if (byte_vld && byte_cnt_q == 2'd0) shadow_q[15:8] <= rx_byte;
    if (byte_vld && byte_cnt_q == 2'd1) shadow_q[7:0]  <= rx_byte;
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    timer_d    = timer_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    overrun_d  = 1'b0;

    // A fresh byte beats a simultaneous timeout.
    if (byte_vld) begin
      timer_d    = '0;
      byte_cnt_d = complete ? 2'd0 : byte_cnt_q + 2'd1;
    end else if (frm_err || byte_cnt_q == 2'd0) begin
      byte_cnt_d = '0;
      timer_d    = '0;
    end else if (timer_q == TO_LAST) begin
      byte_cnt_d = '0;
      timer_d    = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (complete && (!cmd_rdy_q || clr_cmd_rdy)) begin
      cmd_d     = {shadow_q, rx_byte};
      cmd_rdy_d = 1'b1;
    end else if (complete) begin
      overrun_d = 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_cmd_rx_assembler.sv
// Directed bench for cmd_rx_assembler with a transaction-level reference model.
module tb_cmd_rx_assembler;

  localparam int BAUD = 16;
  localparam int TOUT = 2000;
  // From the first edge that sees the start bit: two sync edges to detection,
  // half a bit to mid-start, nine more bits to mid-stop.
  localparam int SAMP_OFS = 2 + BAUD / 2 + 9 * BAUD;

  typedef struct {
    int unsigned samp;
    logic [7:0]  b;
    bit          ok;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_line = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic [23:0] cmd;
  logic        cmd_rdy, frm_err, overrun, rx_busy;

  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int          frm_seen = 0;
  int          ovr_seen = 0;

  ev_t         evq[$];
  logic [23:0] m_cmd = '0;
  logic        m_rdy = 1'b0, m_frm = 1'b0, m_ovr = 1'b0;
  int          m_cnt = 0;
  int unsigned m_last = 0;
  logic [7:0]  m_bytes[3];
  logic [7:0]  nb;
  bit          got;

  cmd_rx_assembler #(
    .BAUD_DIV    (BAUD),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (rx_line),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err),
    .overrun     (overrun),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference model: bytes land one cycle after their stop sample, three make a command.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cmd = '0; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0; m_cnt = 0;
      evq.delete();
    end else begin
      cyc++;
      m_frm = 1'b0; m_ovr = 1'b0; got = 1'b0;
      if (evq.size() > 0) begin
        if (!evq[0].ok && evq[0].samp == cyc) begin
          m_frm = 1'b1; m_cnt = 0;
          void'(evq.pop_front());
        end else if (evq[0].ok && evq[0].samp + 1 == cyc) begin
          got = 1'b1; nb = evq[0].b;
          void'(evq.pop_front());
        end
      end
      if (got) begin
        if (m_cnt != 0 && cyc - m_last > TOUT) m_cnt = 0;
        m_last = cyc;
        m_bytes[m_cnt] = nb;
        m_cnt++;
        if (m_cnt == 3) begin
          m_cnt = 0;
          if (!m_rdy || clr_cmd_rdy) begin
            m_cmd = {m_bytes[0], m_bytes[1], nb};
            m_rdy = 1'b1;
          end else m_ovr = 1'b1;
        end else if (clr_cmd_rdy) m_rdy = 1'b0;
      end else if (clr_cmd_rdy) m_rdy = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cycle", {5'd0, cmd, cmd_rdy, frm_err, overrun}, {5'd0, m_cmd, m_rdy, m_frm, m_ovr});
    if (frm_err) frm_seen++;
    if (overrun) ovr_seen++;
  end

  task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
    ev_t e;
    e.samp = cyc + 1 + SAMP_OFS; e.b = b; e.ok = ok;
    evq.push_back(e);
    rx_line = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx_line = ok;
    repeat (BAUD) @(negedge clk);
    rx_line = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1, 2);
    send_byte(b1, 1'b1, 2);
    send_byte(b2, 1'b1, 2);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int unsigned tgt;
    bit          saw_busy;
    int          idle_at;

    repeat (3) @(negedge clk);
    check("reset_outputs", {4'd0, cmd, cmd_rdy, frm_err, overrun, rx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_cmd(8'hA5, 8'h3C, 8'h0F);
    check("t1_cmd", {8'd0, cmd}, 32'h00A53C0F);
    check("t1_model_cmd", {8'd0, m_cmd}, 32'h00A53C0F);
    check("t1_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("t1_no_frm", frm_seen, 0);
    pulse_clr();
    check("t1_clr_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("t1_clr_cmd_kept", {8'd0, cmd}, 32'h00A53C0F);

    send_byte(8'h11, 1'b1, 2);
    send_byte(8'h22, 1'b0, 3 * BAUD);
    check("frm_pulse", frm_seen, 1);
    send_cmd(8'h44, 8'h55, 8'h66);
    check("frm_next_cmd", {8'd0, cmd}, 32'h00445566);
    pulse_clr();

    send_byte(8'h77, 1'b1, 2);
    send_byte(8'h88, 1'b1, 2500);
    send_cmd(8'h99, 8'hAA, 8'hBB);
    check("tout_cmd", {8'd0, cmd}, 32'h0099AABB);
    check("tout_rdy", {31'd0, cmd_rdy}, 32'd1);
    pulse_clr();

    saw_busy = 1'b0;
    idle_at = -1;
    rx_line = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) rx_line = 1'b1;
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
      else if (saw_busy && idle_at < 0) idle_at = i;
    end
    check("fs_busy_seen", {31'd0, saw_busy}, 32'd1);
    check("fs_busy_back", {31'd0, (idle_at >= 0 && idle_at <= 16)}, 32'd1);
    send_cmd(8'h01, 8'h02, 8'h03);
    check("fs_cmd", {8'd0, cmd}, 32'h00010203);
    check("fs_no_frm", frm_seen, 1);

    send_cmd(8'hDE, 8'hAD, 8'hBE);
    check("ovr_pulse", ovr_seen, 1);
    check("ovr_cmd_kept", {8'd0, cmd}, 32'h00010203);
    check("ovr_rdy_kept", {31'd0, cmd_rdy}, 32'd1);

    send_byte(8'hDE, 1'b1, 2);
    send_byte(8'hAD, 1'b1, 2);
    tgt = cyc + 1 + SAMP_OFS + 1;
    fork
      send_byte(8'hBE, 1'b1, 2);
      begin
        while (cyc + 1 < tgt) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
      end
    join
    check("clrc_cmd", {8'd0, cmd}, 32'h00DEADBE);
    check("clrc_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("clrc_no_ovr", ovr_seen, 1);

    send_byte(8'h12, 1'b1, 2);
    rx_line = 1'b0;
    repeat (BAUD) @(negedge clk);
    rx_line = 1'b0;
    repeat (BAUD + BAUD / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_outputs", {4'd0, cmd, cmd_rdy, frm_err, overrun, rx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_cmd(8'h12, 8'h34, 8'h56);
    check("midrst_cmd", {8'd0, cmd}, 32'h00123456);
    check("midrst_rdy", {31'd0, cmd_rdy}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
